// File: rtl/ymux_sel_reg.sv
// ymux_sel_reg
// N-channel, W-bit selector with one registered output stage.
//
// Channel choice is either direct (mode=0, channel = sel) or round-robin
// (mode=1, first valid channel at or after rr_ptr, wrapping at N).
// The chosen word is captured in a single-entry output register. That
// register can accept a new word whenever it is empty or being popped in
// the same cycle, so it sustains one word per cycle with out_ready held high.
//
// Handshake rule, identical for every input channel and for the output:
// a word moves on a rising edge exactly when its valid and ready are both
// high in the cycle before that edge. Valid never depends on ready. in_ready
// is combinational and has at most one bit set.
//
// Parameters:
//   W  - data width per channel (>= 1)
//   N  - number of input channels (2..16)
//   SW - width of sel, out_chan and the round-robin pointer
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   mode       0 = direct select, 1 = round-robin
//   sel        channel index used in direct mode
//   in_data    flattened channel data; channel i is in_data[i*W +: W]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, one-hot or zero)
//   out_data   registered data word
//   out_chan   index of the channel held in the output register
//   out_valid  output register holds a word
//   out_ready  consumer accepts the held word this cycle
//   out_parity (only with YMUX_SEL_PARITY_EN) XOR reduction of out_data
//
// Optional feature: define YMUX_SEL_PARITY_EN to add the out_parity port.
module ymux_sel_reg #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_chan,
  output logic            out_valid,
`ifdef YMUX_SEL_PARITY_EN
  output logic            out_parity,
`endif
  input  logic            out_ready
);

  // Pointer arithmetic runs one bit wider than SW so that rr_ptr + k and
  // g + 1 never overflow before being reduced modulo N.
  localparam int          SWP1  = SW + 1;
  localparam logic [SW:0] N_EXT = SWP1'(N);

  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_chan_q,  out_chan_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] rr_ptr_q,    rr_ptr_d;
`ifdef YMUX_SEL_PARITY_EN
  logic          out_parity_q, out_parity_d;
`endif

  logic          can_load;
  logic          grant_valid;
  logic [SW-1:0] grant_idx;
  logic [SW:0]   cand;
  logic [SW:0]   rr_next;
  logic [W-1:0]  grant_data;
  logic          transfer;

  assign can_load = !out_valid_q || out_ready;

  // Grant selection. In direct mode a grant exists whenever sel names a
  // real channel, independent of that channel's valid; in round-robin mode
  // a grant exists only when some channel is valid.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (!mode) begin
      if ({1'b0, sel} < N_EXT) begin
        grant_valid = 1'b1;
        grant_idx   = sel;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        cand = {1'b0, rr_ptr_q} + SWP1'(k);
        if (cand >= N_EXT) begin
          cand = cand - N_EXT;
        end
        if (!grant_valid && in_valid[cand[SW-1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = cand[SW-1:0];
        end
      end
    end
  end

  // Ready goes only to the granted channel, and never while in reset
  // (the async reset empties the register, which alone would open can_load).
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = reset_n && can_load && grant_valid && (grant_idx == SW'(i));
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SW'(i)) begin
        grant_data = in_data[i*W +: W];
      end
    end
  end

  assign transfer = reset_n && grant_valid && in_valid[grant_idx] && can_load;

  // Next pointer is g+1 with an explicit wrap, so non-power-of-two N works.
  always_comb begin
    rr_next = {1'b0, grant_idx} + SWP1'(1);
    if (rr_next >= N_EXT) begin
      rr_next = '0;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef YMUX_SEL_PARITY_EN
    out_parity_d = out_parity_q;
`endif
    if (transfer) begin
      // A load in the same cycle as a pop overwrites the word: no bubble.
      out_data_d  = grant_data;
      out_chan_d  = grant_idx;
      out_valid_d = 1'b1;
`ifdef YMUX_SEL_PARITY_EN
      out_parity_d = ^grant_data;
`endif
      if (mode) begin
        rr_ptr_d = rr_next[SW-1:0];
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
`ifdef YMUX_SEL_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef YMUX_SEL_PARITY_EN
      out_parity_q <= out_parity_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
`ifdef YMUX_SEL_PARITY_EN
  assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_ymux_sel_reg.sv
// Testbench for ymux_sel_reg: a W=8/N=4 instance driven by a vector table
// plus hand-written backpressure, reset and parity sequences, and a W=1/N=2
// instance swept over every direct-select combination.
module tb_ymux_sel_reg;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // ---------------- DUT A: W=8, N=4 ----------------
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;
`ifdef YMUX_SEL_PARITY_EN
  logic        out_parity;
`endif

  ymux_sel_reg #(.W(8), .N(4)) dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
`ifdef YMUX_SEL_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_ready (out_ready)
  );

  // ---------------- DUT B: W=1, N=2 ----------------
  logic       mode_b;
  logic       sel_b;
  logic [1:0] in_data_b;
  logic [1:0] in_valid_b;
  logic [1:0] in_ready_b;
  logic       out_data_b;
  logic       out_chan_b;
  logic       out_valid_b;
  logic       out_ready_b;
`ifdef YMUX_SEL_PARITY_EN
  logic       out_parity_b;
`endif

  ymux_sel_reg #(.W(1), .N(2)) dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (mode_b),
    .sel       (sel_b),
    .in_data   (in_data_b),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .out_data  (out_data_b),
    .out_chan  (out_chan_b),
    .out_valid (out_valid_b),
`ifdef YMUX_SEL_PARITY_EN
    .out_parity(out_parity_b),
`endif
    .out_ready (out_ready_b)
  );

  // ---------------- scoreboard ----------------
  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      passed++;
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       out_ready;
    logic [3:0] exp_ready;
    logic       exp_ov;
    logic [7:0] exp_od;
    logic [1:0] exp_oc;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  // Watchdog: nothing here waits on a DUT event, but never hang regardless.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Channel data: ch3=3C ch2=A5 ch1=22 ch0=11.
    // Expected values follow the register contents and rr_ptr from row to row.
    //            mode  sel   valid    ordy  exp_rdy  ov    od     oc
    vecs[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2}; // direct load ch2
    vecs[1]  = '{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0001, 1'b0, 8'hA5, 2'd2}; // pop, nothing valid
    vecs[2]  = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0010, 1'b1, 8'h22, 2'd1}; // empty reg loads
    vecs[3]  = '{1'b0, 2'd3, 4'b1000, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1}; // stalled
    vecs[4]  = '{1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 8'h3C, 2'd3}; // pop + load
    vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0}; // rr 0
    vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1}; // rr 1
    vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2}; // rr 2
    vecs[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h3C, 2'd3}; // rr 3
    vecs[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0}; // rr wraps to 0
    vecs[10] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1}; // rr 1
    vecs[11] = '{1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2}; // rr_ptr -> 3
    vecs[12] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h3C, 2'd3}; // ptr 3: ch3
    vecs[13] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1}; // ptr 0: skip to ch1
    vecs[14] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h3C, 2'd3}; // ptr 2: skip to ch3
    vecs[15] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h3C, 2'd3}; // no grant, pop
    vecs[16] = '{1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h3C, 2'd3}; // idle
    vecs[17] = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2}; // direct, ptr held 0
    vecs[18] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0}; // rr from held ptr 0

    // ---------------- reset with all channels valid ----------------
    reset_n     = 1'b0;
    mode        = 1'b0;
    sel         = 2'd2;
    in_data     = 32'h3C_A5_22_11;
    in_valid    = 4'b1111;
    out_ready   = 1'b1;
    mode_b      = 1'b0;
    sel_b       = 1'b0;
    in_data_b   = 2'b00;
    in_valid_b  = 2'b00;
    out_ready_b = 1'b1;
    tick();
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data",  32'(out_data),  32'd0);
    check("reset out_chan",  32'(out_chan),  32'd0);
    check("reset in_ready",  32'(in_ready),  32'd0);
    check("reset b out_valid", 32'(out_valid_b), 32'd0);
    reset_n = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < NV; i++) begin
      mode      = vecs[i].mode;
      sel       = vecs[i].sel;
      in_valid  = vecs[i].valid;
      out_ready = vecs[i].out_ready;
      #1;
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
      tick();
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("vec%0d out_data", i),  32'(out_data),  32'(vecs[i].exp_od));
      check($sformatf("vec%0d out_chan", i),  32'(out_chan),  32'(vecs[i].exp_oc));
    end

    // ---------------- backpressure ----------------
    mode      = 1'b0;
    sel       = 2'd1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    in_data[15:8] = 8'h3C;
    #1;
    tick();
    check("bp load out_data",  32'(out_data),  32'h3C);
    check("bp load out_valid", 32'(out_valid), 32'd1);
    out_ready     = 1'b0;
    in_data[15:8] = 8'h77;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp stall%0d in_ready", c), 32'(in_ready), 32'd0);
      tick();
      check($sformatf("bp stall%0d out_data", c),  32'(out_data),  32'h3C);
      check($sformatf("bp stall%0d out_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp stall%0d out_chan", c),  32'(out_chan),  32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", 32'(in_ready), 32'b0010);
    tick();
    check("bp release out_data",  32'(out_data),  32'h77);
    check("bp release out_valid", 32'(out_valid), 32'd1);

    // ---------------- mid-stream asynchronous reset ----------------
    // Register holds 77 and rr_ptr is 1 from the table; reset between edges.
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset out_valid", 32'(out_valid), 32'd0);
    check("async reset out_data",  32'(out_data),  32'd0);
    check("async reset in_ready",  32'(in_ready),  32'd0);
    #2;
    reset_n   = 1'b1;
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    in_data   = 32'h3C_A5_22_11;
    #1;
    check("post reset rr in_ready", 32'(in_ready), 32'b0001);
    tick();
    check("post reset rr out_chan", 32'(out_chan), 32'd0);
    check("post reset rr out_data", 32'(out_data), 32'h11);

    // ---------------- parity words ----------------
    mode     = 1'b0;
    sel      = 2'd0;
    in_valid = 4'b0001;
    in_data[7:0] = 8'h07;
    #1;
    tick();
    check("parity word07 out_data", 32'(out_data), 32'h07);
`ifdef YMUX_SEL_PARITY_EN
    check("parity word07 out_parity", 32'(out_parity), 32'd1);
`endif
    in_data[7:0] = 8'h03;
    #1;
    tick();
    check("parity word03 out_data", 32'(out_data), 32'h03);
`ifdef YMUX_SEL_PARITY_EN
    check("parity word03 out_parity", 32'(out_parity), 32'd0);
`endif

    // ---------------- exhaustive W=1 N=2 direct select ----------------
    mode_b      = 1'b0;
    in_valid_b  = 2'b11;
    out_ready_b = 1'b1;
    for (int v = 0; v < 8; v++) begin
      logic c0, c1, s, exp_bit;
      c0 = v[0];
      c1 = v[1];
      s  = v[2];
      exp_bit   = s ? c1 : c0;
      in_data_b = {c1, c0};
      sel_b     = s;
      #1;
      tick();
      check($sformatf("mux2 c0=%0d c1=%0d sel=%0d data", c0, c1, s), 32'(out_data_b), 32'(exp_bit));
      check($sformatf("mux2 c0=%0d c1=%0d sel=%0d chan", c0, c1, s), 32'(out_chan_b), 32'(s));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
